// File: rtl/core_step_ctrl.sv
// Run / single-step / PC-breakpoint controller for the single-cycle Core.
// Conditions the raw step button and produces the per-cycle commit enable.
module core_step_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             aresetn,
    input  logic             step,
    input  logic             debug_mode,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    input  logic [31:0]      pc,
    output logic             core_en,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] step_count
);

    localparam int DW = $clog2(DEB_CYCLES + 1);

    typedef enum logic [1:0] {
        HALT = 2'd0,
        STEP = 2'd1,
        RUN  = 2'd2,
        BRK  = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          sync_1;
    logic          step_s;
    logic          step_db;
    logic          step_db_q;
    logic [DW-1:0] deb_cnt;
    logic          step_evt;
    logic          bp_match;

    // NOTE: every register below uses non-blocking assignment so that all
    // flops sample the pre-edge values of each other, as real hardware does.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sync_1 <= 1'b0;
            step_s <= 1'b0;
        end else begin
            sync_1 <= step;
            step_s <= sync_1;
        end
    end

    // The debounced level only follows step_s after DEB_CYCLES consecutive
    // disagreeing samples; any agreeing sample restarts the count.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            step_db   <= 1'b0;
            step_db_q <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            step_db_q <= step_db;
            if (step_s == step_db) begin
                deb_cnt <= '0;
            end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
                step_db <= step_s;
                deb_cnt <= '0;
            end else begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    assign step_evt = step_db & ~step_db_q;
    assign bp_match = bp_en && (pc == bp_addr);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= HALT;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: defaults first so no path through the case leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        core_en   = 1'b0;
        halted    = 1'b0;
        bp_hit    = 1'b0;
        case (state)
            HALT: begin
                halted = 1'b1;
                if (!debug_mode) begin
                    state_nxt = RUN;
                end else if (step_evt) begin
                    state_nxt = STEP;
                end
            end
            STEP: begin
                core_en   = 1'b1;
                state_nxt = debug_mode ? HALT : RUN;
            end
            RUN: begin
                // The instruction sitting at the breakpoint is held back.
                core_en = !bp_match;
                if (bp_match) begin
                    state_nxt = BRK;
                end else if (debug_mode) begin
                    state_nxt = HALT;
                end
            end
            BRK: begin
                halted = 1'b1;
                bp_hit = 1'b1;
                if (step_evt) begin
                    state_nxt = STEP;
                end else if (!bp_en) begin
                    state_nxt = debug_mode ? HALT : RUN;
                end
            end
            default: begin
                state_nxt = HALT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            step_count <= '0;
        end else if (core_en) begin
            step_count <= step_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_core_step_ctrl.sv
// Randomized and directed bench for core_step_ctrl, checked against a
// cycle-level reference model built from the controller's behavioural rules.
module tb_core_step_ctrl;

    localparam int DEB = 4;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        step;
    logic        debug_mode;
    logic        bp_en;
    logic [31:0] bp_addr;
    logic [31:0] pc;
    logic        core_en;
    logic        halted;
    logic        bp_hit;
    logic [31:0] step_count;
    logic        core_en4;
    logic        halted4;
    logic        bp_hit4;
    logic [3:0]  step_count4;

    always #5 clk = ~clk;

    core_step_ctrl #(.DEB_CYCLES(DEB), .CNT_W(32)) dut (
        .clk(clk), .aresetn(aresetn), .step(step), .debug_mode(debug_mode),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .core_en(core_en),
        .halted(halted), .bp_hit(bp_hit), .step_count(step_count)
    );

    // Narrow-counter instance sharing all inputs, used for wrap behaviour.
    core_step_ctrl #(.DEB_CYCLES(DEB), .CNT_W(4)) dut4 (
        .clk(clk), .aresetn(aresetn), .step(step), .debug_mode(debug_mode),
        .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .core_en(core_en4),
        .halted(halted4), .bp_hit(bp_hit4), .step_count(step_count4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model
    typedef enum {M_HALT, M_STEP, M_RUN, M_BRK} mstate_e;
    mstate_e     ms;
    logic [31:0] m_count;
    bit          pipe[$];
    bit          hist[$];
    bit          m_db;
    bit          m_db_prev;
    bit          m_committed;
    bit          auto_pc;

    function automatic bit m_bp_match();
        return bp_en && (pc == bp_addr);
    endfunction

    function automatic bit m_core_en();
        return (ms == M_STEP) || (ms == M_RUN && !m_bp_match());
    endfunction

    task automatic model_reset();
        ms          = M_HALT;
        m_count     = 0;
        pipe        = '{1'b0, 1'b0};
        hist.delete();
        m_db        = 1'b0;
        m_db_prev   = 1'b0;
        m_committed = 1'b0;
    endtask

    task automatic model_edge();
        bit      evt;
        bit      ss;
        bit      flip;
        mstate_e nx;
        m_committed = m_core_en();
        if (m_committed) m_count++;
        evt = m_db && !m_db_prev;
        nx  = ms;
        case (ms)
            M_HALT: if (!debug_mode) nx = M_RUN; else if (evt) nx = M_STEP;
            M_STEP: nx = debug_mode ? M_HALT : M_RUN;
            M_RUN:  if (m_bp_match()) nx = M_BRK; else if (debug_mode) nx = M_HALT;
            M_BRK:  if (evt) nx = M_STEP; else if (!bp_en) nx = debug_mode ? M_HALT : M_RUN;
        endcase
        ms = nx;
        // Debounced level flips once the last DEB synchronized samples all disagree.
        ss = pipe[0];
        hist.push_back(ss);
        if (hist.size() > DEB) void'(hist.pop_front());
        flip = (hist.size() == DEB);
        foreach (hist[i]) if (hist[i] == m_db) flip = 1'b0;
        m_db_prev = m_db;
        if (flip) begin
            m_db = ss;
            hist.delete();
        end
        pipe.push_back(step);
        void'(pipe.pop_front());
    endtask

    task automatic tick();
        @(posedge clk);
        if (!aresetn) model_reset();
        else model_edge();
        #1;
        if (auto_pc && m_committed) pc = pc + 32'd4;
        #1;
        check("core_en", core_en, m_core_en());
        check("halted", halted, (ms == M_HALT) || (ms == M_BRK));
        check("bp_hit", bp_hit, ms == M_BRK);
        check("step_count", step_count, m_count);
        check("core_en_w4", core_en4, m_core_en());
        check("step_count_w4", step_count4, m_count[3:0]);
    endtask

    task automatic async_reset(input int cycles);
        #2;
        aresetn = 1'b0;
        model_reset();
        #1;
        check("arst_core_en", core_en, 0);
        check("arst_count", step_count, 0);
        check("arst_halted", halted, 1);
        check("arst_bp_hit", bp_hit, 0);
        repeat (cycles) tick();
        aresetn = 1'b1;
    endtask

    initial begin
        int          first;
        int          npulse;
        bit          found;
        bit          wrapped;
        logic [3:0]  prev4;
        logic [31:0] commit_pcs[$];
        int          seg_left;
        bit          level;

        aresetn    = 1'b0;
        step       = 1'b0;
        debug_mode = 1'b1;
        bp_en      = 1'b0;
        bp_addr    = 32'h0;
        pc         = 32'h0;
        auto_pc    = 1'b0;
        model_reset();
        #100;
        aresetn = 1'b1;
        #1;
        check("t1_rst_core_en", core_en, 0);
        check("t1_rst_halted", halted, 1);
        check("t1_rst_count", step_count, 0);

        // Test 1: held step gives one commit at edge k+DEB+3
        tick();
        step   = 1'b1;
        first  = -1;
        npulse = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (core_en) begin
                npulse++;
                if (first < 0) first = i;
            end
        end
        check("t1_latency", first, DEB + 3);
        check("t1_pulses", npulse, 1);
        check("t1_count", step_count, 1);
        check("t1_halted", halted, 1);

        // Test 2: bouncing button is rejected, then a clean press steps once
        step = 1'b0;
        repeat (10) tick();
        npulse = 0;
        for (int c = 0; c < 20; c++) begin
            step = ((c / 2) % 2 == 0);
            tick();
            if (core_en) npulse++;
        end
        repeat (8) begin
            tick();
            if (core_en) npulse++;
        end
        check("t2_bounce_pulses", npulse, 0);
        check("t2_bounce_count", step_count, 1);
        step   = 1'b1;
        npulse = 0;
        repeat (15) begin
            tick();
            if (core_en) npulse++;
        end
        check("t2_clean_pulses", npulse, 1);
        check("t2_clean_count", step_count, 2);
        step = 1'b0;
        repeat (10) tick();

        // Test 3: free run up to a breakpoint at 0x10
        async_reset(2);
        pc         = 32'h0;
        auto_pc    = 1'b1;
        bp_en      = 1'b1;
        bp_addr    = 32'h10;
        debug_mode = 1'b0;
        found      = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (core_en) commit_pcs.push_back(pc);
            if (bp_hit) found = 1'b1;
        end
        check("t3_bp_reached", found, 1);
        check("t3_commits", commit_pcs.size(), 4);
        foreach (commit_pcs[i]) check("t3_commit_pc", commit_pcs[i], 32'(4 * i));
        check("t3_pc", pc, 32'h10);
        check("t3_core_en", core_en, 0);
        check("t3_halted", halted, 1);
        check("t3_count", step_count, 4);

        // Test 4: step over the breakpoint and resume
        step  = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            if (core_en) found = 1'b1;
        end
        check("t4_step_seen", found, 1);
        check("t4_step_pc", pc, 32'h10);
        tick();
        check("t4_resume_pc", pc, 32'h14);
        check("t4_resume_en", core_en, 1);
        check("t4_bp_hit", bp_hit, 0);
        check("t4_halted", halted, 0);
        step = 1'b0;

        // Test 5a: debug_mode drops in the same cycle as step_evt in HALT
        debug_mode = 1'b1;
        bp_en      = 1'b0;
        repeat (2) tick();
        auto_pc = 1'b0;
        bp_en   = 1'b1;
        bp_addr = pc;
        repeat (10) tick();
        check("t5_in_halt", halted, 1);
        tick();
        step = 1'b1;
        repeat (DEB + 2) tick();
        debug_mode = 1'b0;
        tick();
        check("t5_sim_halted", halted, 0);
        check("t5_sim_no_step", core_en, 0);
        tick();
        check("t5_sim_brk", bp_hit, 1);
        step = 1'b0;

        // Test 5b: asynchronous reset in the middle of RUN
        bp_en   = 1'b0;
        auto_pc = 1'b1;
        repeat (5) tick();
        check("t5_running", core_en, 1);
        async_reset(2);

        // Test 6: narrow counter wraps 15 -> 0 -> 1
        wrapped = 1'b0;
        for (int i = 0; i < 40 && m_count != 17; i++) begin
            prev4 = step_count4;
            tick();
            if (prev4 == 4'd15 && step_count4 == 4'd0) wrapped = 1'b1;
        end
        check("t6_wrapped", wrapped, 1);
        check("t6_count_w4", step_count4, 4'd1);
        check("t6_count_w32", step_count, 17);

        // Randomized phase
        seg_left = 0;
        level    = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            if (seg_left == 0) begin
                level    = 1'($urandom_range(0, 1));
                seg_left = $urandom_range(1, 14);
            end
            seg_left--;
            step = ($urandom_range(0, 9) == 0) ? !level : level;
            if ($urandom_range(0, 39) == 0) debug_mode = !debug_mode;
            if ($urandom_range(0, 29) == 0) begin
                bp_en   = !bp_en;
                bp_addr = pc + 32'(4 * $urandom_range(0, 6));
            end
            if ($urandom_range(0, 49) == 0) pc = 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) async_reset($urandom_range(0, 3));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/core_step_ctrl.md
Name: core_step_ctrl

Overview:
- Run/step/breakpoint controller that sequences the single-cycle Core.
- Turns a raw, bouncing step button plus the debug_mode switch into a per-cycle instruction-commit enable (core_en) for the Core.
- Supports free-run, single-step and PC-breakpoint halting, and counts committed cycles for the chip debug outputs.
- Sits between the board inputs and the Core.

Parameters:
DEB_CYCLES, 4, consecutive stable cycles of the synchronized step input needed before the debounced level changes (>=1)
CNT_W, 32, width of step_count

Ports:
clk  in  1  system clock
aresetn  in  1  asynchronous active-low reset
step  in  1  raw step button; asynchronous, may bounce
debug_mode  in  1  1 = halted/single-step operation, 0 = free run
bp_en  in  1  breakpoint enable
bp_addr  in  32  breakpoint PC
pc  in  32  current Core PC, combinational from Core
core_en  out  1  Core commits one instruction in each cycle this is 1
halted  out  1  1 while the controller is in HALT or BRK
bp_hit  out  1  1 while the controller is in BRK
step_count  out  CNT_W  number of cycles with core_en=1; wraps modulo 2^CNT_W

Behaviour:
- Reset: aresetn=0 acts immediately, not on a clock edge. Reset values:
  - state=HALT, core_en=0, halted=1, bp_hit=0, step_count=0
  - sync flops=0, step_db=0, debounce counter=0
- Reset mid-operation aborts everything in flight. No pending step survives reset.
- Input conditioning:
  - step passes through a 2-flop synchronizer to give step_s.
  - The debounce counter counts consecutive cycles in which step_s != step_db. It clears whenever step_s == step_db.
  - When the count reaches DEB_CYCLES, step_db takes the value of step_s and the counter clears.
- Step event: step_evt is 1 for one cycle, in the cycle after step_db goes 0->1. Only rising edges produce events.
- Step latency: step held at 1 from clock edge k gives core_en=1 for exactly one cycle, starting at edge k+DEB_CYCLES+3.
- Button held through reset: after reset releases, a step that is still held produces one step after the debounce period, because step_db resets to 0.
- bp_match = bp_en && (pc == bp_addr). This is a combinational compare on the current cycle's pc.
- core_en is combinational from state:
  - core_en = (state==STEP) || (state==RUN && !bp_match)
  - So the instruction at bp_addr is never executed in RUN.
- FSM. Priority within each state is in the order listed:
  - HALT: debug_mode=0 -> RUN; else step_evt -> STEP; else stay.
  - STEP: core_en=1 for exactly one cycle. Next state is RUN if debug_mode=0, else HALT. step_evt arriving in this cycle is dropped.
  - RUN: bp_match -> BRK; else debug_mode=1 -> HALT; else stay. step_evt is ignored. Leaving RUN on debug_mode=1 takes effect at the next edge, so the instruction in that cycle still commits.
  - BRK: step_evt -> STEP; else bp_en=0 -> RUN if debug_mode=0, else HALT; else stay.
- Stepping out of BRK: STEP is not gated by bp_match, so a step from BRK executes the breakpoint instruction and resumes (RUN) if debug_mode=0.
- Simultaneous events:
  - In HALT, debug_mode=0 together with step_evt -> RUN, and the event is discarded.
  - In RUN, bp_match together with debug_mode=1 -> BRK.
- step_count increments on every clock edge at which core_en=1. It rolls over from all-ones to 0 with no flag.
- halted and bp_hit are decoded from the registered state: halted = HALT or BRK; bp_hit = BRK.

Test Plan:
1. Reset and step (DEB_CYCLES=4, debug_mode=1):
   - Hold aresetn=0 for 100 ns, then release -> core_en=0, halted=1, step_count=0.
   - Raise step at edge k and hold -> core_en=1 only during the cycle at edge k+7, step_count=1, halted stays 1.
2. Bounce rejection:
   - Toggle step 1/0 every 2 cycles for 20 cycles -> no core_en pulse, step_count unchanged.
   - Then hold step=1 -> exactly one pulse.
3. Free run with breakpoint:
   - Set debug_mode=0, bp_en=1, bp_addr=0x10, Core PC advancing by 4 from 0 -> core_en=1 for PCs 0x0, 0x4, 0x8, 0xC.
   - At pc=0x10: core_en=0, then bp_hit=1, halted=1, step_count=4.
4. Step over breakpoint: from test 3, press step -> one core_en cycle at pc=0x10, then RUN resumes at 0x14; bp_hit=0.
5. Simultaneous events and reset:
   - In HALT, drop debug_mode in the same cycle as step_evt -> RUN with no extra STEP cycle.
   - Assert aresetn=0 mid-RUN, between clock edges -> core_en=0 and step_count=0 immediately, without waiting for a clock edge.
6. Counter wrap: CNT_W=4, free run for 17 cycles -> step_count goes 15 -> 0 -> 1.
